// File: rtl/cache_axi_arbiter_pkg.sv
// Shared constants for the icache/dcache memory-port arbiter.
package cache_axi_arbiter_pkg;

  // Requester ids; also used as bit positions in request/grant vectors
  localparam logic IC = 1'b0;
  localparam logic DC = 1'b1;

  // Read FSM encodings
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_BUSY = 1'b1;

  // rd_type encodings seen on the cache/bridge interface
  localparam logic [2:0] RD_BYTE = 3'b000;
  localparam logic [2:0] RD_HALF = 3'b001;
  localparam logic [2:0] RD_WORD = 3'b010;
  localparam logic [2:0] RD_LINE = 3'b100;

endpackage

// File: rtl/cache_axi_arbiter_if.sv
// Cache-side and bridge-side handshake bundle of the memory-port arbiter.
// master: the arbiter's view; slave: the caches/bridge environment view.
interface cache_axi_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  // icache read channel
  logic              ic_rd_req;
  logic [2:0]        ic_rd_type;
  logic [ADDR_W-1:0] ic_rd_addr;
  logic              ic_rd_rdy;
  logic              ic_ret_valid;
  logic              ic_ret_last;
  // dcache read channel
  logic              dc_rd_req;
  logic [2:0]        dc_rd_type;
  logic [ADDR_W-1:0] dc_rd_addr;
  logic              dc_rd_rdy;
  logic              dc_ret_valid;
  logic              dc_ret_last;
  logic [31:0]       ret_data;
  // dcache write-back channel
  logic              dc_wr_req;
  logic [2:0]        dc_wr_type;
  logic [ADDR_W-1:0] dc_wr_addr;
  logic [3:0]        dc_wr_wstrb;
  logic [LINE_W-1:0] dc_wr_data;
  logic              dc_wr_rdy;
  // bridge read side
  logic              mem_rd_req;
  logic [2:0]        mem_rd_type;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_rdy;
  logic              mem_ret_valid;
  logic              mem_ret_last;
  logic [31:0]       mem_ret_data;
  // bridge write side
  logic              mem_wr_req;
  logic [2:0]        mem_wr_type;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [3:0]        mem_wr_wstrb;
  logic [LINE_W-1:0] mem_wr_data;
  logic              mem_wr_rdy;
  logic              mem_wr_done;

  modport master (
    input  ic_rd_req, ic_rd_type, ic_rd_addr,
    output ic_rd_rdy, ic_ret_valid, ic_ret_last,
    input  dc_rd_req, dc_rd_type, dc_rd_addr,
    output dc_rd_rdy, dc_ret_valid, dc_ret_last, ret_data,
    input  dc_wr_req, dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
    output dc_wr_rdy,
    output mem_rd_req, mem_rd_type, mem_rd_addr,
    input  mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
    output mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
    input  mem_wr_rdy, mem_wr_done
  );

  modport slave (
    output ic_rd_req, ic_rd_type, ic_rd_addr,
    input  ic_rd_rdy, ic_ret_valid, ic_ret_last,
    output dc_rd_req, dc_rd_type, dc_rd_addr,
    input  dc_rd_rdy, dc_ret_valid, dc_ret_last, ret_data,
    output dc_wr_req, dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
    input  dc_wr_rdy,
    input  mem_rd_req, mem_rd_type, mem_rd_addr,
    output mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
    input  mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
    output mem_wr_rdy, mem_wr_done
  );

endinterface

// File: rtl/cache_axi_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie, the requester not granted last wins.
module rr_arbiter2
  import cache_axi_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant; tie broken away from the previous winner
  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = '0;
      if (last == IC) gnt[DC] = 1'b1;
      else            gnt[IC] = 1'b1;
    end
  end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares one memory-bridge port between icache and dcache: round-robin reads
// with one read outstanding, beat routing to the owner, and dcache write-back
// forwarding with a read-after-write line hazard block.
module cache_axi_arbiter
  import cache_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LINE_OFF = 4,
  parameter int LINE_W   = 128
) (
  input  logic                clk_g,
  input  logic                resetn,
  cache_axi_arbiter_if.master bus
);

  localparam int LA_W = ADDR_W - LINE_OFF;

  logic [0:0]      rd_state;
  logic            owner;
  logic            rr_last;
  logic            wr_pend;
  logic [LA_W-1:0] wr_line;

  logic [LA_W-1:0] ic_line, dc_line, wr_in_line;
  logic            wr_open, wr_acc;
  logic            ic_haz, dc_haz;
  logic [1:0]      elig, gnt;
  logic            rd_idle, rd_busy, rd_acc;

  assign ic_line    = bus.ic_rd_addr[ADDR_W-1:LINE_OFF];
  assign dc_line    = bus.dc_rd_addr[ADDR_W-1:LINE_OFF];
  assign wr_in_line = bus.dc_wr_addr[ADDR_W-1:LINE_OFF];

  // Write path: combinational pass-through, closed while a write is pending
  assign wr_open          = resetn & ~wr_pend;
  assign bus.mem_wr_req   = wr_open & bus.dc_wr_req;
  assign bus.dc_wr_rdy    = wr_open & bus.mem_wr_rdy;
  assign bus.mem_wr_type  = bus.dc_wr_type;
  assign bus.mem_wr_addr  = bus.dc_wr_addr;
  assign bus.mem_wr_wstrb = bus.dc_wr_wstrb;
  assign bus.mem_wr_data  = bus.dc_wr_data;
  assign wr_acc           = bus.mem_wr_req & bus.mem_wr_rdy;

  // A read must not overtake a write-back to the same line, including one
  // being accepted in this very cycle.
  assign ic_haz = (wr_pend && (ic_line == wr_line)) || (wr_acc && (ic_line == wr_in_line));
  assign dc_haz = (wr_pend && (dc_line == wr_line)) || (wr_acc && (dc_line == wr_in_line));
  assign elig   = {bus.dc_rd_req & ~dc_haz, bus.ic_rd_req & ~ic_haz};

  rr_arbiter2 u_rr (
    .req  (elig),
    .last (rr_last),
    .gnt  (gnt)
  );

  // Read request side: only offered from R_IDLE
  assign rd_idle         = resetn & (rd_state == R_IDLE);
  assign rd_busy         = resetn & (rd_state == R_BUSY);
  assign bus.mem_rd_req  = rd_idle & (|gnt);
  assign bus.mem_rd_type = gnt[DC] ? bus.dc_rd_type : bus.ic_rd_type;
  assign bus.mem_rd_addr = gnt[DC] ? bus.dc_rd_addr : bus.ic_rd_addr;
  assign bus.ic_rd_rdy   = rd_idle & gnt[IC] & bus.mem_rd_rdy;
  assign bus.dc_rd_rdy   = rd_idle & gnt[DC] & bus.mem_rd_rdy;
  assign rd_acc          = bus.mem_rd_req & bus.mem_rd_rdy;

  // Return routing: beats only reach the owner while a read is outstanding
  assign bus.ic_ret_valid = rd_busy & (owner == IC) & bus.mem_ret_valid;
  assign bus.dc_ret_valid = rd_busy & (owner == DC) & bus.mem_ret_valid;
  assign bus.ic_ret_last  = bus.ic_ret_valid & bus.mem_ret_last;
  assign bus.dc_ret_last  = bus.dc_ret_valid & bus.mem_ret_last;
  assign bus.ret_data     = bus.mem_ret_data;

  // Read FSM: idle -> busy on accept, back to idle after the last beat
  always_ff @(posedge clk_g or negedge resetn) begin
    if (!resetn) begin
      rd_state <= R_IDLE;
      owner    <= IC;
      rr_last  <= IC;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_acc) begin
            rd_state <= R_BUSY;
            owner    <= gnt[DC] ? DC : IC;
            rr_last  <= gnt[DC] ? DC : IC;
          end
        end
        R_BUSY: begin
          if (bus.mem_ret_valid && bus.mem_ret_last) rd_state <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Write-pending tracker: set on accept, cleared by the write response
  always_ff @(posedge clk_g or negedge resetn) begin
    if (!resetn) begin
      wr_pend <= 1'b0;
      wr_line <= '0;
    end else if (wr_acc) begin
      wr_pend <= 1'b1;
      wr_line <= wr_in_line;
    end else if (wr_pend && bus.mem_wr_done) begin
      wr_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed self-checking bench for cache_axi_arbiter.
module tb_cache_axi_arbiter;
  import cache_axi_arbiter_pkg::*;

  logic clk_g;
  logic resetn;
  int   n_assert = 0;
  int   n_fail   = 0;

  cache_axi_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus ();

  cache_axi_arbiter #(.ADDR_W(32), .LINE_OFF(4), .LINE_W(128)) dut (
    .clk_g  (clk_g),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk_g = 1'b0;
  always #5 clk_g = ~clk_g;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_g);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.ic_rd_req = 0; bus.ic_rd_type = '0; bus.ic_rd_addr = '0;
    bus.dc_rd_req = 0; bus.dc_rd_type = '0; bus.dc_rd_addr = '0;
    bus.dc_wr_req = 0; bus.dc_wr_type = '0; bus.dc_wr_addr = '0;
    bus.dc_wr_wstrb = '0; bus.dc_wr_data = '0;
    bus.mem_rd_rdy = 0; bus.mem_ret_valid = 0; bus.mem_ret_last = 0;
    bus.mem_ret_data = '0; bus.mem_wr_rdy = 0; bus.mem_wr_done = 0;
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b0;
    // Reset: everything requesting, outputs must stay low
    bus.ic_rd_req = 1; bus.dc_rd_req = 1; bus.dc_wr_req = 1;
    bus.mem_rd_rdy = 1; bus.mem_wr_rdy = 1; bus.mem_ret_valid = 1; bus.mem_ret_last = 1;
    #3;
    chk("rst_mem_rd_req", bus.mem_rd_req, 0);
    chk("rst_mem_wr_req", bus.mem_wr_req, 0);
    chk("rst_ic_rd_rdy", bus.ic_rd_rdy, 0);
    chk("rst_dc_rd_rdy", bus.dc_rd_rdy, 0);
    chk("rst_dc_wr_rdy", bus.dc_wr_rdy, 0);
    chk("rst_ic_ret_valid", bus.ic_ret_valid, 0);
    chk("rst_dc_ret_last", bus.dc_ret_last, 0);
    clear_inputs();
    step(); step();
    resetn = 1'b1;
    settle();

    // icache line read, four beats
    bus.ic_rd_req = 1; bus.ic_rd_type = RD_LINE; bus.ic_rd_addr = 32'h1C00_0000;
    bus.mem_rd_rdy = 1;
    settle();
    chk("t1_mem_rd_req", bus.mem_rd_req, 1);
    chk("t1_mem_rd_type", bus.mem_rd_type, 3'b100);
    chk("t1_mem_rd_addr", bus.mem_rd_addr, 32'h1C00_0000);
    chk("t1_ic_rd_rdy", bus.ic_rd_rdy, 1);
    chk("t1_dc_rd_rdy", bus.dc_rd_rdy, 0);
    step();
    settle();
    chk("t1_busy_no_req", bus.mem_rd_req, 0);
    chk("t1_busy_no_rdy", bus.ic_rd_rdy, 0);
    bus.ic_rd_req = 0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ret_valid = 1;
      bus.mem_ret_data  = 32'hA0 + i;
      bus.mem_ret_last  = (i == 3);
      if (i == 3) bus.dc_rd_req = 1;
      settle();
      chk("t1_ic_ret_valid", bus.ic_ret_valid, 1);
      chk("t1_ic_ret_last", bus.ic_ret_last, (i == 3));
      chk("t1_dc_ret_valid", bus.dc_ret_valid, 0);
      chk("t1_ret_data", bus.ret_data, 32'hA0 + i);
      if (i == 3) chk("t1_no_grant_last_beat", bus.mem_rd_req, 0);
      step();
    end
    bus.dc_rd_req = 0; bus.mem_ret_valid = 0; bus.mem_ret_last = 0;
    // Stray beat while idle
    bus.mem_ret_valid = 1;
    settle();
    chk("stray_ic_ret_valid", bus.ic_ret_valid, 0);
    chk("stray_dc_ret_valid", bus.dc_ret_valid, 0);
    bus.mem_ret_valid = 0;
    step();

    // Fresh reset, then tie: DC, IC, DC with single-beat word reads
    resetn = 1'b0;
    settle();
    resetn = 1'b1;
    settle();
    bus.ic_rd_req = 1; bus.ic_rd_type = RD_WORD; bus.ic_rd_addr = 32'h0000_3000;
    bus.dc_rd_req = 1; bus.dc_rd_type = RD_WORD; bus.dc_rd_addr = 32'h0000_4000;
    bus.mem_rd_rdy = 1;
    for (int k = 0; k < 3; k++) begin
      logic exp_dc;
      exp_dc = (k != 1);
      settle();
      chk("t2_mem_rd_req", bus.mem_rd_req, 1);
      chk("t2_dc_rd_rdy", bus.dc_rd_rdy, exp_dc);
      chk("t2_ic_rd_rdy", bus.ic_rd_rdy, !exp_dc);
      chk("t2_mem_rd_addr", bus.mem_rd_addr, exp_dc ? 32'h0000_4000 : 32'h0000_3000);
      step();
      bus.mem_ret_valid = 1; bus.mem_ret_last = 1; bus.mem_ret_data = 32'h100 + k;
      settle();
      chk("t2_busy_no_req", bus.mem_rd_req, 0);
      chk("t2_dc_ret_valid", bus.dc_ret_valid, exp_dc);
      chk("t2_ic_ret_valid", bus.ic_ret_valid, !exp_dc);
      chk("t2_dc_ret_last", bus.dc_ret_last, exp_dc);
      chk("t2_ic_ret_last", bus.ic_ret_last, !exp_dc);
      step();
      bus.mem_ret_valid = 0; bus.mem_ret_last = 0;
    end
    bus.ic_rd_req = 0; bus.dc_rd_req = 0;

    // Write-back and same-line read in one cycle: read blocked
    bus.dc_wr_req = 1; bus.dc_wr_type = RD_LINE; bus.dc_wr_addr = 32'h0000_1000;
    bus.dc_wr_wstrb = 4'hF; bus.dc_wr_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    bus.mem_wr_rdy = 1;
    bus.dc_rd_req = 1; bus.dc_rd_type = RD_WORD; bus.dc_rd_addr = 32'h0000_100C;
    settle();
    chk("t3_mem_wr_req", bus.mem_wr_req, 1);
    chk("t3_dc_wr_rdy", bus.dc_wr_rdy, 1);
    chk("t3_mem_wr_addr", bus.mem_wr_addr, 32'h0000_1000);
    chk("t3_mem_wr_data", bus.mem_wr_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("t3_mem_wr_wstrb", bus.mem_wr_wstrb, 4'hF);
    chk("t3_same_cycle_blocked", bus.mem_rd_req, 0);
    chk("t3_same_cycle_dc_rdy", bus.dc_rd_rdy, 0);
    step();
    settle();
    chk("t3_second_wr_req", bus.mem_wr_req, 0);
    chk("t3_second_wr_rdy", bus.dc_wr_rdy, 0);
    chk("t3_pend_blocked", bus.mem_rd_req, 0);
    // Different line during pending write is granted
    bus.ic_rd_req = 1; bus.ic_rd_type = RD_WORD; bus.ic_rd_addr = 32'h0000_2000;
    settle();
    chk("t3_other_line_req", bus.mem_rd_req, 1);
    chk("t3_other_line_rdy", bus.ic_rd_rdy, 1);
    chk("t3_other_line_addr", bus.mem_rd_addr, 32'h0000_2000);
    chk("t3_blocked_dc_rdy", bus.dc_rd_rdy, 0);
    step();
    bus.ic_rd_req = 0;
    bus.mem_ret_valid = 1; bus.mem_ret_last = 1;
    settle();
    chk("t3_ic_ret_valid", bus.ic_ret_valid, 1);
    step();
    bus.mem_ret_valid = 0; bus.mem_ret_last = 0;
    settle();
    chk("t3_still_blocked", bus.mem_rd_req, 0);
    bus.mem_wr_done = 1; bus.dc_wr_req = 0;
    settle();
    chk("t3_done_cycle_blocked", bus.mem_rd_req, 0);
    chk("t3_done_cycle_wr_rdy", bus.dc_wr_rdy, 0);
    step();
    bus.mem_wr_done = 0;
    settle();
    chk("t3_after_done_req", bus.mem_rd_req, 1);
    chk("t3_after_done_rdy", bus.dc_rd_rdy, 1);
    chk("t3_after_done_addr", bus.mem_rd_addr, 32'h0000_100C);
    chk("t3_wr_reopened", bus.dc_wr_rdy, 1);
    step();
    bus.dc_rd_req = 0;
    bus.mem_ret_valid = 1; bus.mem_ret_last = 1;
    settle();
    chk("t3_dc_ret_valid", bus.dc_ret_valid, 1);
    chk("t3_dc_ret_last", bus.dc_ret_last, 1);
    step();
    bus.mem_ret_valid = 0; bus.mem_ret_last = 0; bus.mem_wr_rdy = 0;

    // Asynchronous reset in the middle of a line burst
    bus.ic_rd_req = 1; bus.ic_rd_type = RD_LINE; bus.ic_rd_addr = 32'h1C00_0040;
    settle();
    chk("t5_ic_rd_rdy", bus.ic_rd_rdy, 1);
    step();
    bus.ic_rd_req = 0;
    for (int i = 0; i < 2; i++) begin
      bus.mem_ret_valid = 1; bus.mem_ret_data = 32'hB0 + i;
      settle();
      chk("t5_beat", bus.ic_ret_valid, 1);
      step();
    end
    bus.ic_rd_req = 1;
    settle();
    chk("t5_beat3_pre_reset", bus.ic_ret_valid, 1);
    resetn = 1'b0;
    #1;
    chk("t5_rst_ic_ret_valid", bus.ic_ret_valid, 0);
    chk("t5_rst_ic_ret_last", bus.ic_ret_last, 0);
    chk("t5_rst_mem_rd_req", bus.mem_rd_req, 0);
    chk("t5_rst_ic_rd_rdy", bus.ic_rd_rdy, 0);
    bus.ic_rd_req = 0;
    step();
    resetn = 1'b1;
    bus.mem_ret_last = 1;
    settle();
    chk("t5_dropped_beat_valid", bus.ic_ret_valid, 0);
    chk("t5_dropped_beat_last", bus.ic_ret_last, 0);
    step();
    bus.mem_ret_valid = 0; bus.mem_ret_last = 0;
    bus.dc_rd_req = 1; bus.dc_rd_type = RD_WORD; bus.dc_rd_addr = 32'h0000_5000;
    settle();
    chk("t5_new_req", bus.mem_rd_req, 1);
    chk("t5_new_dc_rdy", bus.dc_rd_rdy, 1);
    step();
    bus.dc_rd_req = 0;
    bus.mem_ret_valid = 1; bus.mem_ret_last = 1; bus.mem_ret_data = 32'hC0;
    settle();
    chk("t5_new_dc_ret_valid", bus.dc_ret_valid, 1);
    chk("t5_new_dc_ret_last", bus.dc_ret_last, 1);
    chk("t5_new_ret_data", bus.ret_data, 32'hC0);
    step();
    clear_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_axi_arbiter.md
Name: cache_axi_arbiter

Overview:
- Shares one cache-side memory port (rd/ret/wr handshake to the AXI bridge) between the instruction cache and the data cache.
- Arbitrates read requests round-robin and keeps one read outstanding at a time.
- Routes returned beats to the requesting cache.
- Forwards dcache write-backs and blocks any read to a line whose write-back has not yet completed.

Parameters:
- ADDR_W, 32, address width.
- LINE_OFF, 4, byte-offset bits within a cache line; the line address is addr[ADDR_W-1:LINE_OFF].
- LINE_W, 128, write-back line width.

Ports:
- clk_g  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- ic_rd_req  in  1  icache read request.
- ic_rd_type / ic_rd_addr  in  3/32  icache read type and address.
- ic_rd_rdy  out  1  icache request accepted this cycle.
- ic_ret_valid / ic_ret_last  out  1/1  return beat for icache; last beat marker.
- dc_rd_req  in  1  dcache read request.
- dc_rd_type / dc_rd_addr  in  3/32  dcache read type and address.
- dc_rd_rdy  out  1  dcache request accepted this cycle.
- dc_ret_valid / dc_ret_last  out  1/1  return beat for dcache; last beat marker.
- ret_data  out  32  return data broadcast to both caches (= mem_ret_data).
- dc_wr_req  in  1  dcache write-back request.
- dc_wr_type / dc_wr_addr / dc_wr_wstrb / dc_wr_data  in  3/32/4/LINE_W  write-back fields.
- dc_wr_rdy  out  1  write accepted this cycle.
- mem_rd_req / mem_rd_type / mem_rd_addr  out  1/3/32  read request to bridge.
- mem_rd_rdy  in  1  bridge accepts read.
- mem_ret_valid / mem_ret_last / mem_ret_data  in  1/1/32  bridge return beats.
- mem_wr_req / mem_wr_type / mem_wr_addr / mem_wr_wstrb / mem_wr_data  out  1/3/32/4/LINE_W  write request to bridge.
- mem_wr_rdy  in  1  bridge accepts write.
- mem_wr_done  in  1  one-cycle pulse: write response (B) received.

Behaviour:
- Reset (async, resetn=0): read FSM to R_IDLE; rr_last=IC, so dcache wins the first tie; wr_pend=0.
  - All *_rdy, *_ret_valid, *_ret_last, mem_rd_req and mem_wr_req are 0 while in reset.
  - Reset mid-burst drops the transaction; remaining beats are not routed.
- Read FSM R_IDLE: candidate set = requesters with rd_req=1 and no hazard.
  - Both eligible: grant the one not equal to rr_last.
  - One eligible: grant it.
  - Output mem_rd_req=1 with the granted type/addr (combinational).
  - Granted X_rd_rdy = mem_rd_rdy. The other rdy = 0.
- Acceptance = mem_rd_req & mem_rd_rdy.
  - Go to R_BUSY; owner<=grant; rr_last<=grant.
- R_BUSY: mem_rd_req=0; both rd_rdy=0.
  - mem_ret_valid routes to owner's X_ret_valid. X_ret_last = mem_ret_last & mem_ret_valid.
  - Non-owner ret_valid=0.
  - On mem_ret_valid & mem_ret_last, return to R_IDLE next cycle. No new grant in the last-beat cycle (1-cycle turnaround).
- Beat count is not checked; line reads (type 3'b100, 4 beats) and word reads (3'b010, 1 beat) both end on mem_ret_last.
- mem_ret_valid in R_IDLE is ignored (no ret_valid to either cache).
- Write path W_IDLE: mem_wr_req = dc_wr_req; dc_wr_rdy = mem_wr_rdy; fields pass through unregistered.
  - On accept: wr_pend<=1; wr_line<=dc_wr_addr line address.
- W_PEND: mem_wr_req=0, dc_wr_rdy=0 (one outstanding write).
  - On mem_wr_done, wr_pend<=0 next cycle.
  - A write and mem_wr_done in the same cycle cannot occur (the write is gated by wr_pend).
- Hazard: a read is ineligible if its line address equals wr_line while wr_pend=1, or equals dc_wr_addr line in a cycle where a write is being accepted.
  - Applies to both icache and dcache reads.
  - The read becomes eligible the cycle after mem_wr_done.
- Simultaneous read grant and write accept to different lines: both proceed in the same cycle.
- Requests must hold until rdy; the arbiter never registers request fields. Switching grant while a request is not yet accepted is legal only in R_IDLE by round-robin.

Decomposition:
- Shared package: requester ids (IC=0, DC=1), read FSM encodings (R_IDLE, R_BUSY), rd_type constants (BYTE/HALF/WORD/LINE = 3'b000/001/010/100).
- One sub-module: rr_arbiter2 (2-way round-robin grant, input req[1:0], last; output gnt[1:0]).

Test Plan:
- Reset, then ic_rd_req with addr 0x1C000000 type 100 → mem_rd_req same cycle. With mem_rd_rdy=1, ic_rd_rdy=1. Four ret beats 0xA0..0xA3 → ic_ret_valid x4, ic_ret_last on 4th, dc_ret_valid stays 0.
- ic and dc request together from reset → dc granted first; after its last beat plus 1 idle cycle, ic is granted. Repeat both held → grants alternate DC, IC, DC.
- dc write to 0x00001000 accepted, then dc read 0x0000100C → dc_rd_rdy=0 and mem_rd_req=0 until the cycle after mem_wr_done. A read to 0x00002000 during wr_pend is granted immediately.
- Second dc_wr_req while wr_pend=1 → dc_wr_rdy=0 until mem_wr_done. A write and a same-line read in the same cycle → the read is blocked.
- Word read (type 010) with a single beat mem_ret_last=1 → owner ret_last=1 and FSM idle next cycle. Stray mem_ret_valid in idle → no ret_valid.
- resetn deasserted asynchronously mid-burst (after beat 2) → all outputs 0 immediately. Subsequent beats are ignored and a new request is granted normally after reset release.
